// File: rtl/wiphy_axil_pkg.sv
// rtl/wiphy_axil_pkg.sv - shared AXI4-Lite types and constants for the wiphy register path
//
// Contents:
//   resp_t                 2-bit BRESP/RRESP code
//   OKAY/EXOKAY/SLVERR/DECERR response codes
//   AXIL_DATA_WIDTH/AXIL_STRB_WIDTH fixed data path geometry
//   axil_master_state_t    state encoding of axil_cmd_master
package wiphy_axil_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t OKAY   = 2'b00;
  localparam resp_t EXOKAY = 2'b01;
  localparam resp_t SLVERR = 2'b10;
  localparam resp_t DECERR = 2'b11;

  localparam int AXIL_DATA_WIDTH = 32;
  localparam int AXIL_STRB_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_RESP         = 3'd5
  } axil_master_state_t;

endpackage

// File: rtl/axil_cmd_master_if.sv
// rtl/axil_cmd_master_if.sv - AXI4-Lite bus bundle between axil_cmd_master and a register slave
//
// Parameter ADDR_WIDTH: width of awaddr/araddr.
// Signals: AW (awvalid/awready/awaddr/awprot), W (wvalid/wready/wdata/wstrb),
//          B (bvalid/bready/bresp), AR (arvalid/arready/araddr/arprot),
//          R (rvalid/rready/rdata/rresp).
// Modports: master (initiator side), slave (target side).
interface axil_cmd_master_if
  import wiphy_axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
);

  logic                         awvalid;
  logic                         awready;
  logic [ADDR_WIDTH-1:0]        awaddr;
  logic [2:0]                   awprot;

  logic                         wvalid;
  logic                         wready;
  logic [AXIL_DATA_WIDTH-1:0]   wdata;
  logic [AXIL_STRB_WIDTH-1:0]   wstrb;

  logic                         bvalid;
  logic                         bready;
  resp_t                        bresp;

  logic                         arvalid;
  logic                         arready;
  logic [ADDR_WIDTH-1:0]        araddr;
  logic [2:0]                   arprot;

  logic                         rvalid;
  logic                         rready;
  logic [AXIL_DATA_WIDTH-1:0]   rdata;
  resp_t                        rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - command/response to single AXI4-Lite transaction initiator
//
// Optional feature macro: AXIL_CMD_MASTER_TIMEOUT_EN (watchdog + timeout port).
// Parameters: ADDR_WIDTH (16), DATA_WIDTH (32, only 32 supported),
//             TIMEOUT (1024 cycles, watchdog limit).
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake; cmd_write, cmd_addr, cmd_wdata, cmd_wstrb
//   rsp_valid/rsp_ready    response handshake; rsp_data (0 for writes), rsp_resp
//   m_axi                  AXI4-Lite master bus (axil_cmd_master_if.master)
//   timeout                sticky watchdog flag (macro builds only)
module axil_cmd_master
  import wiphy_axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [ADDR_WIDTH-1:0]       cmd_addr,
  input  logic [AXIL_DATA_WIDTH-1:0]  cmd_wdata,
  input  logic [AXIL_STRB_WIDTH-1:0]  cmd_wstrb,

  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXIL_DATA_WIDTH-1:0]  rsp_data,
  output resp_t                       rsp_resp,

  axil_cmd_master_if.master           m_axi
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  ,
  output logic                        timeout
`endif
);

  if (DATA_WIDTH != AXIL_DATA_WIDTH) begin : g_bad_data_width
    $error("axil_cmd_master supports only a 32-bit data path");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("axil_cmd_master TIMEOUT must be at least 1");
  end

  axil_master_state_t state;

  // A write channel is finished once its valid is low (already handshaken)
  // or it handshakes this cycle; AW and W may complete in either order.
  logic aw_last;
  logic w_last;

  always_comb begin
    aw_last = !m_axi.awvalid || m_axi.awready;
    w_last  = !m_axi.wvalid  || m_axi.wready;
  end

  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_resp      <= OKAY;
      m_axi.awvalid <= 1'b0;
      m_axi.awaddr  <= '0;
      m_axi.wvalid  <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.wstrb   <= '0;
      m_axi.bready  <= 1'b0;
      m_axi.arvalid <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.rready  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m_axi.awaddr  <= cmd_addr;
              m_axi.wdata   <= cmd_wdata;
              m_axi.wstrb   <= cmd_wstrb;
              m_axi.awvalid <= 1'b1;
              m_axi.wvalid  <= 1'b1;
              state         <= ST_WR_ADDR_DATA;
            end else begin
              m_axi.araddr  <= cmd_addr;
              m_axi.arvalid <= 1'b1;
              state         <= ST_RD_ADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        ST_WR_ADDR_DATA: begin
          if (m_axi.awvalid && m_axi.awready) m_axi.awvalid <= 1'b0;
          if (m_axi.wvalid && m_axi.wready)   m_axi.wvalid  <= 1'b0;
          if (aw_last && w_last) begin
            m_axi.bready <= 1'b1;
            state        <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          // bready is high for the whole state, so bvalid alone is the handshake.
          if (m_axi.bvalid) begin
            m_axi.bready <= 1'b0;
            rsp_data     <= '0;
            rsp_resp     <= m_axi.bresp;
            rsp_valid    <= 1'b1;
            state        <= ST_RESP;
          end
        end

        ST_RD_ADDR: begin
          if (m_axi.arready) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
            state         <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (m_axi.rvalid) begin
            m_axi.rready <= 1'b0;
            rsp_data     <= m_axi.rdata;
            rsp_resp     <= m_axi.rresp;
            rsp_valid    <= 1'b1;
            state        <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);

  axil_master_state_t state_prev;
  logic [CNT_W-1:0]   wd_cnt;
  logic [CNT_W-1:0]   wd_cnt_next;
  logic               in_wait;

  // The count restarts at 1 on the first cycle of each waiting state so that
  // it equals the number of cycles spent there; it saturates at the limit.
  always_comb begin
    in_wait     = state inside {ST_WR_ADDR_DATA, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA};
    wd_cnt_next = wd_cnt;
    if (in_wait) begin
      if (state != state_prev) begin
        wd_cnt_next = CNT_W'(1);
      end else if (wd_cnt != WD_LIMIT) begin
        wd_cnt_next = wd_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_prev <= ST_IDLE;
      wd_cnt     <= '0;
      timeout    <= 1'b0;
    end else begin
      state_prev <= state;
      wd_cnt     <= wd_cnt_next;
      if (in_wait && (wd_cnt_next == WD_LIMIT)) timeout <= 1'b1;
    end
  end
`endif

endmodule
